eeprom_spi_ctrl: RTL and testbench



---
 rtl/eeprom_spi_if.sv | 26 ++
 rtl/eeprom_spi_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_eeprom_spi_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eeprom_spi_if.sv
// Request/response and SPI pin bundle for eeprom_spi_ctrl.
// The controller uses the slave modport; the requester/EEPROM side uses master.
interface eeprom_spi_if;
    logic       start;
    logic       op;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       busy;
    logic       done;
    logic       err;
    logic       cs_n;
    logic       sck;
    logic       mosi;
    logic       miso;

    modport master (
        output start, op, addr, wdata, miso,
        input  rdata, busy, done, err, cs_n, sck, mosi
    );

    modport slave (
        input  start, op, addr, wdata, miso,
        output rdata, busy, done, err, cs_n, sck, mosi
    );
endinterface

// File: rtl/eeprom_spi_ctrl.sv
// SPI mode-0 transaction controller for a 128x8 serial EEPROM (READ, WREN/WRITE/RDSR polling).
// Optional poll timeout with err pulse is enabled by defining POLL_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for a start rising edge
// LOAD  | request captured, next edge opens the first frame
// WREN  | 8-bit write-enable frame
// GAP1  | cs_n high between WREN and WRITE
// WRITE | 24-bit write frame
// GAP2  | cs_n high before each status poll
// POLL  | 16-bit RDSR frame, WIP decides repeat or finish
// READ  | 24-bit read frame
// FIN   | one-cycle done (and err) pulse
module eeprom_spi_ctrl #(
    parameter int CLK_DIV = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    eeprom_spi_if.slave  bus
);
    typedef enum logic [3:0] {IDLE, LOAD, WREN, GAP1, WRITE, GAP2, POLL, READ, FIN} state_t;

    localparam logic [8:0] HALF = 9'(CLK_DIV - 1);
    localparam logic [8:0] GAP  = 9'(2 * CLK_DIV - 1);

    state_t      state;
    state_t      nxt_frame;
    logic        start_d1, start_d2, launch;
    logic        op_q;
    logic [6:0]  addr_q;
    logic [7:0]  wdata_q;
    logic [22:0] sh;
    logic [4:0]  bit_cnt;
    logic [8:0]  tmr;
    logic        tmr_tc;
    logic        tail;
    logic [7:0]  rx;
    logic [7:0]  rdata_q;
    logic        busy_q, done_q, cs_n_q, sck_q, mosi_q;
    logic [23:0] fr_data;
    logic [4:0]  fr_len;
`ifdef POLL_TIMEOUT_EN
    logic [7:0]  poll_cnt;
    logic        tout;
    logic        err_q;
`endif

    assign launch = start_d1 & ~start_d2;
    assign tmr_tc = (tmr == 9'd0);

    // Contents of the frame that the current state opens next; fr_len is bits minus one.
    always_comb begin
        fr_data   = {8'h05, 16'h0000};
        fr_len    = 5'd15;
        nxt_frame = POLL;
        case (state)
            LOAD: begin
                if (op_q) begin
                    fr_data   = {8'h06, 16'h0000};
                    fr_len    = 5'd7;
                    nxt_frame = WREN;
                end else begin
                    fr_data   = {8'h03, 1'b0, addr_q, 8'h00};
                    fr_len    = 5'd23;
                    nxt_frame = READ;
                end
            end
            GAP1: begin
                fr_data   = {8'h02, 1'b0, addr_q, wdata_q};
                fr_len    = 5'd23;
                nxt_frame = WRITE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            start_d1 <= 1'b0;
            start_d2 <= 1'b0;
            op_q     <= 1'b0;
            addr_q   <= 7'd0;
            wdata_q  <= 8'd0;
            sh       <= 23'd0;
            bit_cnt  <= 5'd0;
            tmr      <= 9'd0;
            tail     <= 1'b0;
            rx       <= 8'd0;
            rdata_q  <= 8'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b0;
`ifdef POLL_TIMEOUT_EN
            poll_cnt <= 8'd0;
            tout     <= 1'b0;
            err_q    <= 1'b0;
`endif
        end else begin
            start_d1 <= bus.start;
            start_d2 <= start_d1;
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
`ifdef POLL_TIMEOUT_EN
                    err_q  <= 1'b0;
`endif
                    if (launch) begin
                        state   <= LOAD;
                        busy_q  <= 1'b1;
                        op_q    <= bus.op;
                        addr_q  <= bus.addr;
                        wdata_q <= bus.wdata;
`ifdef POLL_TIMEOUT_EN
                        poll_cnt <= 8'd0;
                        tout     <= 1'b0;
`endif
                    end
                end
                LOAD, GAP1, GAP2: begin
                    if (state == LOAD || tmr_tc) begin
                        state   <= nxt_frame;
                        cs_n_q  <= 1'b0;
                        sck_q   <= 1'b0;
                        mosi_q  <= fr_data[23];
                        sh      <= fr_data[22:0];
                        bit_cnt <= fr_len;
                        tmr     <= HALF;
                        tail    <= 1'b0;
                    end else begin
                        tmr <= tmr - 9'd1;
                    end
                end
                WREN, WRITE, POLL, READ: begin
                    if (!tmr_tc) begin
                        tmr <= tmr - 9'd1;
                    end else begin
                        tmr <= HALF;
                        if (tail) begin
                            cs_n_q <= 1'b1;
                            tmr    <= GAP;
                            case (state)
                                WREN:  state <= GAP1;
                                WRITE: state <= GAP2;
                                READ: begin
                                    rdata_q <= rx;
                                    state   <= FIN;
                                end
                                default: begin
                                    if (rx[0]) begin
`ifdef POLL_TIMEOUT_EN
                                        if (poll_cnt == 8'd254) begin
                                            tout  <= 1'b1;
                                            state <= FIN;
                                        end else begin
                                            poll_cnt <= poll_cnt + 8'd1;
                                            state    <= GAP2;
                                        end
`else
                                        state <= GAP2;
`endif
                                    end else begin
                                        state <= FIN;
                                    end
                                end
                            endcase
                        end else if (!sck_q) begin
                            sck_q <= 1'b1;
                            rx    <= {rx[6:0], bus.miso};
                        end else begin
                            sck_q <= 1'b0;
                            if (bit_cnt == 5'd0) begin
                                tail   <= 1'b1;
                                mosi_q <= 1'b0;
                            end else begin
                                bit_cnt <= bit_cnt - 5'd1;
                                mosi_q  <= sh[22];
                                sh      <= {sh[21:0], 1'b0};
                            end
                        end
                    end
                end
                FIN: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
`ifdef POLL_TIMEOUT_EN
                    err_q  <= tout;
`endif
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.cs_n  = cs_n_q;
    assign bus.sck   = sck_q;
    assign bus.mosi  = mosi_q;
`ifdef POLL_TIMEOUT_EN
    assign bus.err   = err_q;
`else
    assign bus.err   = 1'b0;
`endif
endmodule

// File: tb/tb_eeprom_spi_ctrl.sv
// Bench for eeprom_spi_ctrl: behavioural EEPROM on the pins, expected frames and done
// results queued by the stimulus and popped by independent frame and done monitors.
module tb_eeprom_spi_ctrl;
    localparam int CLK_DIV = 4;
    localparam int PER     = 10;

    typedef struct {
        int          nbits;
        int          nchk;
        logic [31:0] hdr;
        bit          chk_gap;
    } frame_t;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
    } done_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    eeprom_spi_if bus();

    eeprom_spi_ctrl #(.CLK_DIV(CLK_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #(PER / 2) clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int frame_cnt   = 0;
    int done_cnt    = 0;

    frame_t exp_fq[$];
    done_t  exp_dq[$];

    logic [7:0] eemem   [128];
    logic [7:0] ref_mem [128];
    logic [7:0] ref_rdata = 8'h00;
    int         wip_left  = 0;
    int         wip_cfg   = 0;
    bit         wel       = 1'b0;

    int          bitn = 0;
    logic [31:0] cap  = 32'd0;
    logic [7:0]  cmd  = 8'd0;
    logic [7:0]  rd_byte = 8'd0;
    logic [7:0]  status  = 8'd0;
    time         t_fall = 0;
    time         t_prev_rise = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // EEPROM pin model: shifts mosi on sck rise, presents response bits after sck fall.
    always @(negedge bus.cs_n) begin
        t_fall = $time;
        bitn   = 0;
        cap    = 32'd0;
        cmd    = 8'd0;
    end

    always @(posedge bus.sck) begin
        if (bus.cs_n === 1'b0) begin
            cap = {cap[30:0], bus.mosi};
            bitn++;
        end
    end

    always @(negedge bus.sck) begin
        if (bus.cs_n === 1'b0 && rst_n === 1'b1) begin
            if (bitn == 8) begin
                cmd    = cap[7:0];
                status = {7'b0, wip_left > 0};
            end
            if (bitn == 16 && cmd == 8'h03) rd_byte = eemem[cap[6:0]];
            if (cmd == 8'h03 && bitn >= 16 && bitn < 24)
                bus.miso = rd_byte[23 - bitn];
            else if (cmd == 8'h05 && bitn >= 8 && bitn < 16)
                bus.miso = status[15 - bitn];
            else
                bus.miso = 1'b0;
        end
    end

    always @(posedge bus.cs_n) begin : frame_mon
        frame_t      e;
        logic [31:0] hdr;
        if (rst_n === 1'b1) begin
            if (exp_fq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_frame: got %0d-bit frame cmd %0h, expected no frame", bitn, cmd);
            end else begin
                e = exp_fq.pop_front();
                check("frame_bits", 32'(bitn), 32'(e.nbits));
                hdr = (bitn >= e.nchk) ? ((cap >> (bitn - e.nchk)) & ((32'd1 << e.nchk) - 32'd1))
                                       : 32'hFFFF_FFFF;
                check("frame_hdr", hdr, e.hdr);
                check("cs_low_cycles", 32'(int'(($time - t_fall) / PER)), 32'((2 * e.nbits + 1) * CLK_DIV));
                if (e.chk_gap)
                    check("gap_cycles", 32'(int'((t_fall - t_prev_rise) / PER)), 32'(2 * CLK_DIV));
            end
            if (cmd == 8'h06 && bitn == 8) begin
                wel = 1'b1;
            end else if (cmd == 8'h02 && bitn == 24) begin
                if (wel) begin
                    eemem[cap[14:8]] = cap[7:0];
                    wip_left = wip_cfg;
                end
                wel = 1'b0;
            end else if (cmd == 8'h05 && wip_left > 0) begin
                wip_left--;
            end
            frame_cnt++;
        end
        t_prev_rise = $time;
    end

    always @(negedge clk) begin : done_mon
        done_t d;
        if (rst_n === 1'b1) begin
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (exp_dq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done: got done=1, expected no done");
                end else begin
                    d = exp_dq.pop_front();
                    check("rdata", 32'(bus.rdata), 32'(d.rdata));
                    check("err", 32'(bus.err), 32'(d.err));
                end
            end else if (bus.err === 1'b1) begin
                vectors++;
                miscompares++;
                $display("FAIL err_without_done: got err=1 done=0, expected err=0");
            end
        end
    end

    task automatic push_frame(input int nbits, input int nchk, input logic [31:0] hdr, input bit gap);
        frame_t f;
        f.nbits   = nbits;
        f.nchk    = nchk;
        f.hdr     = hdr;
        f.chk_gap = gap;
        exp_fq.push_back(f);
    endtask

    task automatic expect_txn(input bit op, input logic [6:0] a, input logic [7:0] d,
                              input int polls, input bit to);
        done_t r;
        if (!op) begin
            push_frame(24, 16, 32'({8'h03, 1'b0, a}), 1'b0);
            ref_rdata = ref_mem[a];
        end else begin
            push_frame(8, 8, 32'h06, 1'b0);
            push_frame(24, 24, 32'({8'h02, 1'b0, a, d}), 1'b1);
            for (int i = 0; i < polls; i++) push_frame(16, 8, 32'h05, 1'b1);
            ref_mem[a] = d;
        end
        r.rdata = ref_rdata;
        r.err   = to;
        exp_dq.push_back(r);
    endtask

    task automatic launch(input bit op, input logic [6:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.op    = op;
        bus.addr  = a;
        bus.wdata = d;
        bus.start = 1'b1;
    endtask

    task automatic wait_done(input int lim);
        bit seen = 1'b0;
        for (int i = 0; i < lim && !seen; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        check("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic release_start();
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic txn(input bit op, input logic [6:0] a, input logic [7:0] d, input int wip);
        wip_cfg = wip;
        expect_txn(op, a, d, op ? wip + 1 : 0, 1'b0);
        launch(op, a, d);
        wait_done((wip + 2) * 200 + 600);
        release_start();
    endtask

    task automatic reset_pulse();
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_cs_n", 32'(bus.cs_n), 32'd1);
        check("rst_sck", 32'(bus.sck), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_mosi", 32'(bus.mosi), 32'd0);
        exp_fq.delete();
        exp_dq.delete();
        ref_rdata = 8'h00;
        wip_left  = 0;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rdata_after_reset", 32'(bus.rdata), 32'd0);
    endtask

    initial begin
        int         n0, d0, f0;
        logic [6:0] a;
        logic [7:0] d;
        logic [7:0] saved;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.addr  = 7'd0;
        bus.wdata = 8'd0;
        bus.miso  = 1'b0;
        for (int i = 0; i < 128; i++) begin
            eemem[i]   = 8'($urandom);
            ref_mem[i] = eemem[i];
        end
        eemem[7'h15]   = 8'hA5;
        ref_mem[7'h15] = 8'hA5;

        repeat (3) @(negedge clk);
        check("reset_cs_n", 32'(bus.cs_n), 32'd1);
        check("reset_sck", 32'(bus.sck), 32'd0);
        check("reset_mosi", 32'(bus.mosi), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_err", 32'(bus.err), 32'd0);
        check("reset_rdata", 32'(bus.rdata), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed read with launch latency
        expect_txn(1'b0, 7'h15, 8'h00, 0, 1'b0);
        @(negedge clk);
        bus.op    = 1'b0;
        bus.addr  = 7'h15;
        bus.start = 1'b1;
        n0 = cyc + 1;
        @(negedge clk);
        check("busy_in_launch_cycle", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check("busy_in_load", 32'(bus.busy), 32'd1);
        wait_done(400);
        check("read_latency", 32'(cyc - n0), 32'd199);
        release_start();
        check("rdata_held", 32'(bus.rdata), 32'hA5);

        // Directed write with three busy polls, then read back
        txn(1'b1, 7'h7F, 8'h3C, 3);
        txn(1'b0, 7'h7F, 8'h00, 0);

        for (int i = 0; i < 14; i++) begin
            a = 7'($urandom_range(0, 7));
            d = 8'($urandom);
            txn(1'($urandom_range(0, 1)), a, d, int'($urandom_range(0, 2)));
        end

        // start held high: only one transaction
        d0 = done_cnt;
        a  = 7'($urandom_range(0, 127));
        expect_txn(1'b0, a, 8'h00, 0, 1'b0);
        launch(1'b0, a, 8'h00);
        repeat (1000) @(negedge clk);
        check("held_start_dones", 32'(done_cnt - d0), 32'd1);
        release_start();
        txn(1'b0, 7'h7F, 8'h00, 0);

        // Second edge during an active write is dropped
        d0 = done_cnt;
        f0 = frame_cnt;
        a  = 7'h40;
        d  = 8'($urandom);
        wip_cfg = 2;
        expect_txn(1'b1, a, d, 3, 1'b0);
        launch(1'b1, a, d);
        repeat (60) @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        bus.start = 1'b1;
        repeat (20) @(negedge clk);
        bus.start = 1'b0;
        wait_done(2000);
        repeat (300) @(negedge clk);
        check("busy_edge_frames", 32'(frame_cnt - f0), 32'd5);
        check("busy_edge_dones", 32'(done_cnt - d0), 32'd1);
        txn(1'b0, a, 8'h00, 0);

        // Reset in the middle of the WRITE frame
        saved   = ref_mem[7'h22];
        wip_cfg = 0;
        expect_txn(1'b1, 7'h22, 8'h99, 1, 1'b0);
        f0 = frame_cnt;
        launch(1'b1, 7'h22, 8'h99);
        for (int i = 0; i < 300 && frame_cnt == f0; i++) @(negedge clk);
        repeat (50) @(negedge clk);
        check("mid_write_cs_low", 32'(bus.cs_n), 32'd0);
        reset_pulse();
        ref_mem[7'h22] = saved;
        txn(1'b0, 7'h22, 8'h00, 0);
        txn(1'b1, 7'h22, 8'h99, 0);
        txn(1'b0, 7'h22, 8'h00, 0);

        // WIP stuck at 1
        a = 7'h5A;
        d = 8'($urandom);
        wip_cfg = 1000000;
`ifdef POLL_TIMEOUT_EN
        expect_txn(1'b1, a, d, 255, 1'b1);
        launch(1'b1, a, d);
        wait_done(255 * 150 + 2000);
        release_start();
        wip_left = 0;
`else
        expect_txn(1'b1, a, d, 400, 1'b0);
        f0 = frame_cnt;
        launch(1'b1, a, d);
        for (int i = 0; i < 50000 && (frame_cnt - f0) < 303; i++) @(negedge clk);
        check("polls_over_300", 32'((frame_cnt - f0 - 2) > 300), 32'd1);
        check("busy_while_polling", 32'(bus.busy), 32'd1);
        reset_pulse();
`endif
        txn(1'b0, a, 8'h00, 0);

        check("frames_left", 32'(exp_fq.size()), 32'd0);
        check("dones_left", 32'(exp_dq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #(PER * 150000);
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog expired");
    end
endmodule
